// File: rtl/mpe_seq_ctrl.sv
// Sequencer for one MPE column: weight load, diagonally staggered fmap stream, psum drain.
// Latency: LOAD_W one cycle after accepted start, first psum valid NUMBER_PE+PSUM_LAT cycles after that.
// Backpressure: i_stall freezes all sequencing and zeroes strobes/enables that cycle. Optional MPE_SEQ_ABORT_EN adds i_abort.
module mpe_seq_ctrl #(
   parameter int NUMBER_PE = 9,
   parameter int PSUM_LAT  = 4,
   parameter int VEC_W     = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rest_n,
   input  logic                 i_start,
   input  logic [VEC_W-1:0]     i_num_vec,
   input  logic                 i_stall,
`ifdef MPE_SEQ_ABORT_EN
   input  logic                 i_abort,
`endif
   output logic                 o_busy,
   output logic                 o_weight_en,
   output logic [NUMBER_PE-1:0] o_left_en,
   output logic [NUMBER_PE-1:0] o_right_en,
   output logic [NUMBER_PE-1:0] o_fmap_rd,
   output logic                 o_psum_valid,
   output logic [VEC_W-1:0]     o_vec_cnt,
   output logic                 o_done
);

   // Counter width one bit wider than the vector count so N+NUMBER_PE-1 never wraps.
   localparam int CW = VEC_W + 1;
   localparam int DW = (PSUM_LAT > 1) ? $clog2(PSUM_LAT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_W,
      S_STREAM,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                 r_state;
   logic [VEC_W-1:0]       r_n;
   logic [CW-1:0]          r_s;
   logic [DW-1:0]          r_drain;
   logic [PSUM_LAT-1:0]    r_pipe;
   logic [VEC_W-1:0]       r_vec_cnt;
   logic                   r_weight;
   logic [NUMBER_PE-1:0]   r_rd;
   logic [NUMBER_PE-1:0]   r_en;
   logic                   r_done;

   logic                   w_active;
   logic                   w_stall;
   logic                   w_abort;
   logic [CW-1:0]          w_s_last;
   logic [CW-1:0]          w_s_next;
   logic                   w_pipe_in;

   // Column k reads while k <= s <= k+N-1: a window of N strobes sliding one column per step.
   function automatic logic [NUMBER_PE-1:0] f_window(input logic [CW-1:0] s,
                                                      input logic [CW-1:0] n);
      logic [NUMBER_PE-1:0] v;
      v = '0;
      for (int k = 0; k < NUMBER_PE; k++) begin
         v[k] = (s >= CW'(k)) && (s < (CW'(k) + n));
      end
      return v;
   endfunction

   // PE k is enabled once the stream step reaches k and stays on (thermometer fill).
   function automatic logic [NUMBER_PE-1:0] f_therm(input logic [CW-1:0] s);
      logic [NUMBER_PE-1:0] v;
      v = '0;
      for (int k = 0; k < NUMBER_PE; k++) begin
         v[k] = (s >= CW'(k));
      end
      return v;
   endfunction

`ifdef MPE_SEQ_ABORT_EN
   assign w_abort = i_abort;
`else
   assign w_abort = 1'b0;
`endif

   assign w_active  = (r_state == S_LOAD_W) || (r_state == S_STREAM) || (r_state == S_DRAIN);
   assign w_stall   = i_stall & w_active;
   assign w_s_last  = {1'b0, r_n} + CW'(NUMBER_PE) - CW'(2);
   assign w_s_next  = r_s + CW'(1);

   // Registered strobes are masked for the stalled cycle only; they reappear when stall drops.
   assign o_busy       = (r_state != S_IDLE);
   assign o_weight_en  = r_weight & ~w_stall;
   assign o_fmap_rd    = r_rd & {NUMBER_PE{~w_stall}};
   assign o_left_en    = r_en & {NUMBER_PE{~w_stall}};
   assign o_right_en   = r_en & {NUMBER_PE{~w_stall}};
   assign o_psum_valid = r_pipe[PSUM_LAT-1] & ~w_stall;
   assign o_vec_cnt    = r_vec_cnt;
   assign o_done       = r_done;

   // The last column's read strobe feeds the psum latency pipe.
   assign w_pipe_in = o_fmap_rd[NUMBER_PE-1];

   // Job FSM, stream/drain counters, psum pipe and emitted-psum counter.
   always_ff @(posedge i_clk or negedge i_rest_n) begin
      if (!i_rest_n) begin
         r_state   <= S_IDLE;
         r_n       <= '0;
         r_s       <= '0;
         r_drain   <= '0;
         r_pipe    <= '0;
         r_vec_cnt <= '0;
         r_weight  <= 1'b0;
         r_rd      <= '0;
         r_en      <= '0;
         r_done    <= 1'b0;
      end else if (w_abort && (r_state != S_IDLE)) begin
         // Abort wins over stall and normal progress; the psum count is kept for inspection.
         r_state  <= S_IDLE;
         r_s      <= '0;
         r_drain  <= '0;
         r_pipe   <= '0;
         r_weight <= 1'b0;
         r_rd     <= '0;
         r_en     <= '0;
         r_done   <= 1'b0;
      end else begin
         if (o_psum_valid && (r_vec_cnt != {VEC_W{1'b1}})) begin
            r_vec_cnt <= r_vec_cnt + VEC_W'(1);
         end

         if (((r_state == S_STREAM) || (r_state == S_DRAIN)) && !i_stall) begin
            for (int i = PSUM_LAT - 1; i > 0; i--) begin
               r_pipe[i] <= r_pipe[i-1];
            end
            r_pipe[0] <= w_pipe_in;
         end

         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_n       <= i_num_vec;
                  r_vec_cnt <= '0;
                  r_weight  <= 1'b1;
                  r_state   <= S_LOAD_W;
               end
            end

            S_LOAD_W: begin
               if (!i_stall) begin
                  r_weight <= 1'b0;
                  if (r_n == '0) begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_s     <= '0;
                     r_rd    <= f_window('0, {1'b0, r_n});
                     r_en    <= f_therm('0);
                     r_state <= S_STREAM;
                  end
               end
            end

            S_STREAM: begin
               if (!i_stall) begin
                  if (r_s == w_s_last) begin
                     // Every PE is already enabled here because N >= 1.
                     r_rd    <= '0;
                     r_drain <= '0;
                     r_state <= S_DRAIN;
                  end else begin
                     r_s  <= w_s_next;
                     r_rd <= f_window(w_s_next, {1'b0, r_n});
                     r_en <= f_therm(w_s_next);
                  end
               end
            end

            S_DRAIN: begin
               if (!i_stall) begin
                  if (r_drain == DW'(PSUM_LAT - 1)) begin
                     r_en    <= '0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_drain <= r_drain + DW'(1);
                  end
               end
            end

            S_DONE: begin
               r_done  <= 1'b0;
               r_en    <= '0;
               r_rd    <= '0;
               r_pipe  <= '0;
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mpe_seq_ctrl.sv
// Self-checking bench for mpe_seq_ctrl: directed timing checks plus randomized jobs against an effective-time model.
// Model counts un-stalled job cycles and derives every output from that count with plain arithmetic.
// Inputs driven #1 after the rising edge, outputs sampled on the falling edge.
module tb_mpe_seq_ctrl;

   localparam int NP  = 9;
   localparam int LAT = 4;
   localparam int VW  = 16;

   logic          clk;
   logic          i_rest_n;
   logic          i_start;
   logic [VW-1:0] i_num_vec;
   logic          i_stall;
`ifdef MPE_SEQ_ABORT_EN
   logic          i_abort;
`endif
   logic          o_busy;
   logic          o_weight_en;
   logic [NP-1:0] o_left_en;
   logic [NP-1:0] o_right_en;
   logic [NP-1:0] o_fmap_rd;
   logic          o_psum_valid;
   logic [VW-1:0] o_vec_cnt;
   logic          o_done;

   mpe_seq_ctrl #(.NUMBER_PE(NP), .PSUM_LAT(LAT), .VEC_W(VW)) dut (
      .i_clk        (clk),
      .i_rest_n     (i_rest_n),
      .i_start      (i_start),
      .i_num_vec    (i_num_vec),
      .i_stall      (i_stall),
`ifdef MPE_SEQ_ABORT_EN
      .i_abort      (i_abort),
`endif
      .o_busy       (o_busy),
      .o_weight_en  (o_weight_en),
      .o_left_en    (o_left_en),
      .o_right_en   (o_right_en),
      .o_fmap_rd    (o_fmap_rd),
      .o_psum_valid (o_psum_valid),
      .o_vec_cnt    (o_vec_cnt),
      .o_done       (o_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   // Reference model: job active flag, effective (un-stalled) cycle index, job size, psum count.
   logic m_active = 1'b0;
   int   m_e      = 0;
   int   m_n      = 0;
   int   m_vec    = 0;

   // Cycle bookkeeping for directed timing checks (offsets relative to the start cycle).
   int cyc_idx     = 0;
   int t0          = 0;
   int first_valid = -1;
   int last_valid  = -1;
   int done_off    = -1;
   int rd_seen     = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Effective cycles a job spends before DONE: weight load, stream, drain.
   function automatic int job_len(input int n);
      return (n == 0) ? 1 : n + NP + LAT;
   endfunction

   task automatic cyc(input logic st, input logic [VW-1:0] nv, input logic stl, input logic ab);
      int            tl;
      int            s;
      logic          se;
      logic          ab_eff;
      logic          e_weight;
      logic          e_valid;
      logic          e_done;
      logic [NP-1:0] e_rd;
      logic [NP-1:0] e_en;

      i_start   = st;
      i_num_vec = nv;
      i_stall   = stl;
`ifdef MPE_SEQ_ABORT_EN
      i_abort   = ab;
      ab_eff    = ab;
`else
      ab_eff    = ab & 1'b0;
`endif
      @(negedge clk);

      tl       = job_len(m_n);
      s        = m_e - 1;
      se       = stl && m_active && (m_e < tl);
      e_weight = m_active && (m_e == 0) && !se;
      e_done   = m_active && (m_e == tl);
      e_valid  = m_active && (m_n > 0) && (m_e >= NP + LAT) && (m_e <= NP + LAT + m_n - 1) && !se;
      e_rd     = '0;
      e_en     = '0;
      for (int k = 0; k < NP; k++) begin
         if (m_active && (m_n > 0) && (m_e >= 1) && (m_e <= m_n + NP - 1)) begin
            e_rd[k] = (s >= k) && (s <= k + m_n - 1) && !se;
            e_en[k] = (s >= k) && !se;
         end else if (m_active && (m_n > 0) && (m_e >= m_n + NP) && (m_e <= tl - 1)) begin
            e_en[k] = !se;
         end
      end

      check("busy",       32'(o_busy),       32'(m_active));
      check("weight_en",  32'(o_weight_en),  32'(e_weight));
      check("fmap_rd",    32'(o_fmap_rd),    32'(e_rd));
      check("left_en",    32'(o_left_en),    32'(e_en));
      check("right_en",   32'(o_right_en),   32'(e_en));
      check("psum_valid", 32'(o_psum_valid), 32'(e_valid));
      check("done",       32'(o_done),       32'(e_done));
      check("vec_cnt",    32'(o_vec_cnt),    32'(m_vec));

      if (o_psum_valid === 1'b1) begin
         if (first_valid < 0) first_valid = cyc_idx - t0;
         last_valid = cyc_idx - t0;
      end
      if ((o_done === 1'b1) && (done_off < 0)) done_off = cyc_idx - t0;
      if (o_fmap_rd !== '0) rd_seen++;

      @(posedge clk);
      #1;
      if (!m_active) begin
         if (st) begin
            m_active = 1'b1;
            m_e      = 0;
            m_n      = int'(nv);
            m_vec    = 0;
         end
      end else if (ab_eff) begin
         m_active = 1'b0;
      end else if (m_e == tl) begin
         m_active = 1'b0;
      end else begin
         if (e_valid && (m_vec < (1 << VW) - 1)) m_vec++;
         if (!se) m_e++;
      end
      cyc_idx++;
   endtask

   task automatic job_start(input logic [VW-1:0] nv);
      t0          = cyc_idx;
      first_valid = -1;
      last_valid  = -1;
      done_off    = -1;
      rd_seen     = 0;
      cyc(1'b1, nv, 1'b0, 1'b0);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0);
   endtask

   // Assert reset mid-cycle, confirm outputs drop without a clock edge, then release.
   task automatic do_reset(input int hold);
      i_rest_n = 1'b0;
      #2;
      check("rst_busy",    32'(o_busy),       32'd0);
      check("rst_weight",  32'(o_weight_en),  32'd0);
      check("rst_fmap_rd", 32'(o_fmap_rd),    32'd0);
      check("rst_left",    32'(o_left_en),    32'd0);
      check("rst_right",   32'(o_right_en),   32'd0);
      check("rst_valid",   32'(o_psum_valid), 32'd0);
      check("rst_vec",     32'(o_vec_cnt),    32'd0);
      check("rst_done",    32'(o_done),       32'd0);
      m_active = 1'b0;
      m_e      = 0;
      m_vec    = 0;
      repeat (hold) @(posedge clk);
      @(negedge clk);
      i_start  = 1'b0;
      i_rest_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic n3_timing(input string tag);
      job_start(16'd3);
      idle_cycles(22);
      check({tag, "_first_valid"}, 32'(first_valid), 32'd14);
      check({tag, "_last_valid"},  32'(last_valid),  32'd16);
      check({tag, "_done_at"},     32'(done_off),    32'd17);
      check({tag, "_vec_cnt"},     32'(o_vec_cnt),   32'd3);
   endtask

   initial begin
      i_rest_n  = 1'b0;
      i_start   = 1'b1;
      i_num_vec = 16'd7;
      i_stall   = 1'b0;
`ifdef MPE_SEQ_ABORT_EN
      i_abort   = 1'b0;
`endif

      // Reset held with start high: all quiet, and no job after release.
      #3;
      do_reset(3);
      idle_cycles(5);

      // N=3 baseline timing.
      n3_timing("t2");

      // N=3 with a two-cycle stall at offsets 5..6: everything after shifts by two.
      job_start(16'd3);
      for (int i = 1; i <= 24; i++) cyc(1'b0, '0, (i == 5) || (i == 6), 1'b0);
      check("t3_first_valid", 32'(first_valid), 32'd16);
      check("t3_last_valid",  32'(last_valid),  32'd18);
      check("t3_done_at",     32'(done_off),    32'd19);
      check("t3_vec_cnt",     32'(o_vec_cnt),   32'd3);

      // N=0: straight to DONE, second start during the job ignored.
      job_start(16'd0);
      cyc(1'b1, 16'd5, 1'b0, 1'b0);
      idle_cycles(4);
      check("t4_done_at",  32'(done_off),    32'd2);
      check("t4_no_valid", 32'(first_valid), 32'hFFFF_FFFF);
      check("t4_no_rd",    32'(rd_seen),     32'd0);
      check("t4_idle",     32'(o_busy),      32'd0);

      // Reset mid-job at offset 8, then a clean rerun of the N=3 timing.
      job_start(16'd3);
      idle_cycles(7);
      do_reset(2);
      check("t5_no_done", 32'(done_off), 32'hFFFF_FFFF);
      idle_cycles(3);
      n3_timing("t5");

`ifdef MPE_SEQ_ABORT_EN
      // Abort at offset 7 of an N=5 job: back to IDLE, no done, count untouched.
      job_start(16'd5);
      idle_cycles(6);
      cyc(1'b0, '0, 1'b0, 1'b1);
      check("t6_idle_after_abort", 32'(o_busy), 32'd0);
      idle_cycles(20);
      check("t6_no_done", 32'(done_off),  32'hFFFF_FFFF);
      check("t6_vec_cnt", 32'(o_vec_cnt), 32'd0);
`endif

      // Randomized jobs, stalls and stray starts, checked cycle by cycle against the model.
      for (int i = 0; i < 1500; i++) begin
         logic          r_st;
         logic          r_sl;
         logic          r_ab;
         logic [VW-1:0] r_nv;
         r_st = ($urandom_range(0, 5) == 0);
         r_sl = ($urandom_range(0, 4) == 0);
         r_nv = ($urandom_range(0, 9) == 0) ? VW'($urandom_range(0, 30)) : VW'($urandom_range(0, 6));
`ifdef MPE_SEQ_ABORT_EN
         r_ab = ($urandom_range(0, 60) == 0);
`else
         r_ab = 1'b0;
`endif
         cyc(r_st, r_nv, r_sl, r_ab);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
